// File: rtl/ram_loader_pkg.sv
// Shared state encoding and width helper for the RAM loader and its packer.
// No logic; pure declarations.
// Backpressure: n/a.
package ram_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_CLEAR   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Bytes needed to fill one RAM word; the last byte may be partially used.
    function automatic int nbytes_of(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/ram_loader_byte_packer.sv
// Little-endian byte-to-word assembler with byte counter and full flag.
// Latency: word_nxt/last are combinational from the accepted byte.
// Backpressure: bytes are ignored once full until clr.
module byte_packer #(
    parameter int WIDTH  = 16,
    parameter int NBYTES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             acc,
    input  logic [7:0]       byte_in,
    output logic [WIDTH-1:0] word_nxt,
    output logic             last,
    output logic             full
);

    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(NBYTES - 1);

    logic [CW-1:0]         cnt;
    logic [8*NBYTES-1:0]   asm_q;
    logic [8*NBYTES-1:0]   asm_nxt;
    logic                  take;

    assign take = acc & ~full;

    always_comb begin
        asm_nxt = asm_q;
        for (int k = 0; k < NBYTES; k++) begin
            if (cnt == CW'(k)) begin
                asm_nxt[8*k +: 8] = byte_in;
            end
        end
        word_nxt = asm_nxt[WIDTH-1:0];
        last     = take && (cnt == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            asm_q <= '0;
            full  <= 1'b0;
        end else if (clr) begin
            cnt   <= '0;
            asm_q <= '0;
            full  <= 1'b0;
        end else if (take) begin
            asm_q <= asm_nxt;
            if (cnt == CNT_MAX) begin
                cnt  <= '0;
                full <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_loader.sv
// Loads a byte stream into RAM as packed words, or zero-fills the whole RAM.
// Latency: NBYTES accept cycles + 1 write cycle per word; done one cycle after last write.
// Backpressure: byte_ready high only while collecting; byte_valid low simply stalls.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  clear,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [WIDTH-1:0]      ram_din,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_write_en,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int NBYTES = nbytes_of(WIDTH);
    localparam logic [ADDR_WIDTH:0]   MAX_LEN   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t              state;
    logic [ADDR_WIDTH:0] len_q;
    logic [ADDR_WIDTH:0] len_clamped;
    logic [ADDR_WIDTH:0] count_inc;
    logic                pk_clr;
    logic                pk_acc;
    logic                pk_last;
    logic                pk_full;
    logic [WIDTH-1:0]    pk_word;

    assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
    assign count_inc   = count + 1'b1;
    assign pk_acc      = byte_valid & byte_ready;
    // The assembly register is emptied in every state but COLLECT, so WRITE clears it.
    assign pk_clr      = (state != ST_COLLECT);

    byte_packer #(
        .WIDTH  (WIDTH),
        .NBYTES (NBYTES)
    ) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (pk_clr),
        .acc      (pk_acc),
        .byte_in  (byte_in),
        .word_nxt (pk_word),
        .last     (pk_last),
        .full     (pk_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            len_q        <= '0;
            byte_ready   <= 1'b0;
            ram_din      <= '0;
            ram_addr     <= '0;
            ram_write_en <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            count        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear) begin
                        state        <= ST_CLEAR;
                        busy         <= 1'b1;
                        count        <= '0;
                        ram_addr     <= '0;
                        ram_din      <= '0;
                        ram_write_en <= 1'b1;
                    end else if (start) begin
                        len_q    <= len_clamped;
                        busy     <= 1'b1;
                        count    <= '0;
                        ram_addr <= '0;
                        if (len_clamped == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= ST_COLLECT;
                            byte_ready <= 1'b1;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (pk_last && !pk_full) begin
                        state        <= ST_WRITE;
                        byte_ready   <= 1'b0;
                        ram_din      <= pk_word;
                        ram_write_en <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    ram_write_en <= 1'b0;
                    count        <= count_inc;
                    ram_addr     <= ram_addr + 1'b1;
                    if (count_inc == len_q) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state      <= ST_COLLECT;
                        byte_ready <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    count <= count_inc;
                    if (ram_addr == LAST_ADDR) begin
                        state        <= ST_DONE;
                        ram_write_en <= 1'b0;
                        done         <= 1'b1;
                    end else begin
                        ram_addr <= ram_addr + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
